// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-outstanding memory bus between a core's fetch and data ports.
// Build option: define ARB_RR_EN for round-robin arbitration on ties (default: data has priority).
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic              i_rd_i,
  output logic [31:0]       i_data_o,
  output logic              i_ready_o,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_data_i,
  input  logic              d_rd_i,
  input  logic              d_wr_i,
  output logic [31:0]       d_data_o,
  output logic              d_ready_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [31:0]       m_data_o,
  output logic              m_rd_o,
  output logic              m_wr_o,
  input  logic [31:0]       m_data_i,
  input  logic              m_ack_i
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t state_reg;
  logic   d_pend;
  logic   i_pend;
  logic   grant_d;

  // A requester sees its ready pulse only at the next edge, so its request is
  // still up during that cycle; masking it stops the access being re-issued.
  assign d_pend = (d_rd_i | d_wr_i) & ~d_ready_o;
  assign i_pend = i_rd_i & ~i_ready_o;

`ifdef ARB_RR_EN
  logic last_d_reg;  // 1 when the data port received the most recent grant

  assign grant_d = d_pend & (~i_pend | ~last_d_reg);
`else
  assign grant_d = d_pend;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg <= IDLE;
      i_data_o  <= '0;
      i_ready_o <= 1'b0;
      d_data_o  <= '0;
      d_ready_o <= 1'b0;
      m_addr_o  <= '0;
      m_data_o  <= '0;
      m_rd_o    <= 1'b0;
      m_wr_o    <= 1'b0;
`ifdef ARB_RR_EN
      last_d_reg <= 1'b0;
`endif
    end else begin
      i_ready_o <= 1'b0;
      d_ready_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_d) begin
            // A simultaneous load+store request is carried out as the store.
            state_reg <= GNT_D;
            m_addr_o  <= d_addr_i;
            m_data_o  <= d_wr_i ? d_data_i : 32'd0;
            m_wr_o    <= d_wr_i;
            m_rd_o    <= ~d_wr_i;
`ifdef ARB_RR_EN
            last_d_reg <= 1'b1;
`endif
          end else if (i_pend) begin
            state_reg <= GNT_I;
            m_addr_o  <= i_addr_i;
            m_data_o  <= 32'd0;
            m_wr_o    <= 1'b0;
            m_rd_o    <= 1'b1;
`ifdef ARB_RR_EN
            last_d_reg <= 1'b0;
`endif
          end
        end
        GNT_I: begin
          if (m_ack_i) begin
            state_reg <= IDLE;
            m_rd_o    <= 1'b0;
            m_wr_o    <= 1'b0;
            i_ready_o <= 1'b1;
            i_data_o  <= m_data_i;
          end
        end
        GNT_D: begin
          if (m_ack_i) begin
            state_reg <= IDLE;
            m_rd_o    <= 1'b0;
            m_wr_o    <= 1'b0;
            d_ready_o <= 1'b1;
            d_data_o  <= m_wr_o ? 32'd0 : m_data_i;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed protocol cases, then randomized traffic
// against a bus-level memory model with expected responses queued per requester.
module tb_mem_arbiter;
  localparam int AW = 32;

`ifdef ARB_RR_EN
  localparam bit TIE2_I_FIRST = 1'b1;
`else
  localparam bit TIE2_I_FIRST = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [AW-1:0] i_addr_i;
  logic          i_rd_i;
  logic [31:0]   i_data_o;
  logic          i_ready_o;
  logic [AW-1:0] d_addr_i;
  logic [31:0]   d_data_i;
  logic          d_rd_i;
  logic          d_wr_i;
  logic [31:0]   d_data_o;
  logic          d_ready_o;
  logic [AW-1:0] m_addr_o;
  logic [31:0]   m_data_o;
  logic          m_rd_o;
  logic          m_wr_o;
  logic [31:0]   m_data_i;
  logic          m_ack_i;

  int checks = 0;
  int passes = 0;
  bit mem_auto = 1'b0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic [63:0] wq[$];
  logic i_rdy_q = 1'b0;
  logic d_rdy_q = 1'b0;

  mem_arbiter #(.ADDR_W(AW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .i_addr_i(i_addr_i), .i_rd_i(i_rd_i), .i_data_o(i_data_o), .i_ready_o(i_ready_o),
    .d_addr_i(d_addr_i), .d_data_i(d_data_i), .d_rd_i(d_rd_i), .d_wr_i(d_wr_i),
    .d_data_o(d_data_o), .d_ready_o(d_ready_o),
    .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_rd_o(m_rd_o), .m_wr_o(m_wr_o),
    .m_data_i(m_data_i), .m_ack_i(m_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Contents the memory model returns for any read address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Scoreboard monitor: every ready pulse pops the expected data for that port.
  always @(negedge clk_i) begin
    if (i_ready_o || d_ready_o)
      check("ready_exclusive", {i_ready_o, d_ready_o} == 2'b11, 0);
    if (i_ready_o) begin
      check("i_single_pulse", i_rdy_q, 0);
      check("i_expected_txn", iq.size() != 0, 1);
      if (iq.size() != 0) check("i_data", i_data_o, iq.pop_front());
      $display("txn fetch  data=%08h", i_data_o);
    end
    if (d_ready_o) begin
      check("d_single_pulse", d_rdy_q, 0);
      check("d_expected_txn", dq.size() != 0, 1);
      if (dq.size() != 0) check("d_data", d_data_o, dq.pop_front());
      $display("txn data   data=%08h", d_data_o);
    end
    i_rdy_q <= i_ready_o;
    d_rdy_q <= d_ready_o;
  end

  // Randomized memory: acks 1..3 cycles after a strobe, sometimes acks while idle.
  initial begin : mem_model
    logic [31:0] a, wd, rnd;
    logic r, w;
    logic [63:0] we;
    int n;
    forever begin
      @(posedge clk_i); #1;
      if (mem_auto) begin
        m_ack_i = 1'b0;
        if (m_rd_o || m_wr_o) begin
          a = m_addr_o; wd = m_data_o; r = m_rd_o; w = m_wr_o;
          check("strobe_exclusive", r & w, 0);
          if (w) begin
            check("write_expected", wq.size() != 0, 1);
            if (wq.size() != 0) begin
              we = wq.pop_front();
              check("write_addr", a, we[63:32]);
              check("write_data", wd, we[31:0]);
            end
          end
          n = $urandom_range(1, 3);
          for (int k = 1; k < n; k++) begin
            @(posedge clk_i); #1;
            check("bus_stable", {m_addr_o, m_data_o, m_rd_o, m_wr_o}, {a, wd, r, w});
          end
          rnd = $urandom;
          m_ack_i = 1'b1;
          m_data_i = w ? rnd : mem_f(a);
          @(posedge clk_i); #1;
          m_ack_i = 1'b0;
          check("strobe_drop", {m_rd_o, m_wr_o}, 0);
        end else if ($urandom_range(0, 7) == 0) begin
          m_ack_i = 1'b1;
          m_data_i = $urandom;
        end
      end
    end
  end

  // Called just after the grant edge; acks after 'waits' strobe cycles.
  task automatic serve(input string tag, input logic [31:0] ea, input logic erd, input logic ewr,
                       input logic [31:0] ed, input bit chk_d, input int waits, input logic [31:0] rdata);
    check({tag, "_addr"}, m_addr_o, ea);
    check({tag, "_strobes"}, {m_rd_o, m_wr_o}, {erd, ewr});
    if (chk_d) check({tag, "_mdata"}, m_data_o, ed);
    for (int k = 1; k < waits; k++) begin
      @(posedge clk_i); #1;
      check({tag, "_hold"}, {m_addr_o, m_rd_o, m_wr_o}, {ea, erd, ewr});
    end
    m_ack_i = 1'b1;
    m_data_i = rdata;
    @(posedge clk_i); #1;
    m_ack_i = 1'b0;
    check({tag, "_strobe_drop"}, {m_rd_o, m_wr_o}, 0);
  endtask

  task automatic i_txn(input logic [31:0] a);
    int n = 0;
    i_addr_i = a; i_rd_i = 1'b1;
    iq.push_back(mem_f(a));
    do begin @(posedge clk_i); #1; n++; end while (!i_ready_o && n < 60);
    check("i_wait_bound", n < 60, 1);
    i_rd_i = 1'b0; i_addr_i = $urandom;
  endtask

  task automatic d_txn(input logic [31:0] a, input logic [31:0] wd, input int op);
    int n = 0;
    d_addr_i = a; d_data_i = wd;
    d_rd_i = (op != 1); d_wr_i = (op != 0);
    if (op == 0) dq.push_back(mem_f(a));
    else begin dq.push_back(32'd0); wq.push_back({a, wd}); end
    do begin @(posedge clk_i); #1; n++; end while (!d_ready_o && n < 60);
    check("d_wait_bound", n < 60, 1);
    d_rd_i = 1'b0; d_wr_i = 1'b0; d_addr_i = $urandom; d_data_i = $urandom;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] fa, sa, fd, sd;
    rst_n_i = 1'b0; i_addr_i = '0; i_rd_i = 1'b0; d_addr_i = '0; d_data_i = '0;
    d_rd_i = 1'b0; d_wr_i = 1'b0; m_data_i = '0; m_ack_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_ctrl", {i_ready_o, d_ready_o, m_rd_o, m_wr_o, m_addr_o}, 0);
    check("reset_data", {i_data_o, d_data_o, m_data_o}, 0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Ack while idle is ignored.
    m_ack_i = 1'b1; m_data_i = 32'h11112222;
    @(posedge clk_i); #1;
    m_ack_i = 1'b0;
    @(posedge clk_i); #1;
    check("idle_ack_ignored", {i_ready_o, d_ready_o, m_rd_o, m_wr_o, i_data_o, d_data_o}, 0);

    // Tie after reset: data wins in either arbitration mode, fetch follows.
    i_addr_i = 32'h40; i_rd_i = 1'b1; d_addr_i = 32'h300; d_rd_i = 1'b1;
    iq.push_back(32'hA0A00040); dq.push_back(32'hD0D00300);
    @(posedge clk_i); #1;
    serve("tie1_first", 32'h300, 1, 0, 0, 0, 1, 32'hD0D00300);
    check("tie1_d_ready", d_ready_o, 1);
    d_rd_i = 1'b0;
    @(posedge clk_i); #1;
    serve("tie1_second", 32'h40, 1, 0, 32'h0, 1, 1, 32'hA0A00040);
    check("tie1_i_ready", i_ready_o, 1);
    i_rd_i = 1'b0;
    @(posedge clk_i); #1;

    // Store.
    d_addr_i = 32'h100; d_data_i = 32'hDEADBEEF; d_wr_i = 1'b1;
    dq.push_back(32'd0);
    @(posedge clk_i); #1;
    serve("store", 32'h100, 0, 1, 32'hDEADBEEF, 1, 3, 32'h12345678);
    check("store_ready", d_ready_o, 1);
    d_wr_i = 1'b0;
    @(posedge clk_i); #1;

    // Tie after a data grant: round-robin favours fetch, fixed priority data.
    i_addr_i = 32'h48; i_rd_i = 1'b1; d_addr_i = 32'h308; d_rd_i = 1'b1;
    iq.push_back(32'hA0A00048); dq.push_back(32'hD0D00308);
    fa = TIE2_I_FIRST ? 32'h48 : 32'h308;  sa = TIE2_I_FIRST ? 32'h308 : 32'h48;
    fd = TIE2_I_FIRST ? 32'hA0A00048 : 32'hD0D00308;
    sd = TIE2_I_FIRST ? 32'hD0D00308 : 32'hA0A00048;
    @(posedge clk_i); #1;
    serve("tie2_first", fa, 1, 0, 0, 0, 1, fd);
    check("tie2_first_ready", {i_ready_o, d_ready_o}, TIE2_I_FIRST ? 2'b10 : 2'b01);
    if (i_ready_o) i_rd_i = 1'b0;
    if (d_ready_o) d_rd_i = 1'b0;
    @(posedge clk_i); #1;
    serve("tie2_second", sa, 1, 0, 0, 0, 1, sd);
    check("tie2_second_ready", {i_ready_o, d_ready_o}, TIE2_I_FIRST ? 2'b01 : 2'b10);
    i_rd_i = 1'b0; d_rd_i = 1'b0;
    @(posedge clk_i); #1;

    // Fetch with ack two cycles after the strobe, then data hold.
    i_addr_i = 32'h10; i_rd_i = 1'b1;
    iq.push_back(32'h00500093);
    @(posedge clk_i); #1;
    serve("fetch", 32'h10, 1, 0, 32'h0, 1, 2, 32'h00500093);
    check("fetch_ready", i_ready_o, 1);
    i_rd_i = 1'b0;
    @(posedge clk_i); #1;
    check("fetch_ready_drop", i_ready_o, 0);
    check("fetch_data_hold", i_data_o, 32'h00500093);

    // Load and store together: only the write strobe.
    d_addr_i = 32'h200; d_data_i = 32'hCAFEF00D; d_rd_i = 1'b1; d_wr_i = 1'b1;
    dq.push_back(32'd0);
    @(posedge clk_i); #1;
    serve("rdwr", 32'h200, 0, 1, 32'hCAFEF00D, 1, 1, 32'h55555555);
    d_rd_i = 1'b0; d_wr_i = 1'b0;
    @(posedge clk_i); #1;

    // Fetch withdrawn mid-grant still completes on the granted address.
    i_addr_i = 32'h80; i_rd_i = 1'b1;
    iq.push_back(32'h13572468);
    @(posedge clk_i); #1;
    i_rd_i = 1'b0; i_addr_i = 32'hFFF0;
    serve("withdraw", 32'h80, 1, 0, 32'h0, 1, 3, 32'h13572468);
    check("withdraw_ready", i_ready_o, 1);
    @(posedge clk_i); #1;

    // Reset during a data grant aborts it; the late ack is ignored.
    d_addr_i = 32'h400; d_rd_i = 1'b1;
    @(posedge clk_i); #1;
    check("abort_granted", {m_rd_o, m_addr_o}, {1'b1, 32'h400});
    rst_n_i = 1'b0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1; d_rd_i = 1'b0;
    check("abort_outs", {m_rd_o, m_wr_o, d_ready_o, i_ready_o, m_addr_o, d_data_o}, 0);
    m_ack_i = 1'b1; m_data_i = 32'h77777777;
    @(posedge clk_i); #1;
    m_ack_i = 1'b0;
    check("abort_late_ack", {d_ready_o, i_ready_o, m_rd_o, m_wr_o}, 0);
    i_addr_i = 32'h44; i_rd_i = 1'b1;
    iq.push_back(32'h0BADC0DE);
    @(posedge clk_i); #1;
    serve("post_abort", 32'h44, 1, 0, 32'h0, 1, 1, 32'h0BADC0DE);
    i_rd_i = 1'b0;
    @(posedge clk_i); #1;

    // Randomized traffic against the memory model.
    mem_auto = 1'b1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
          i_txn($urandom & 32'h0000FFFC);
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
          d_txn($urandom & 32'h0000FFFC, $urandom, $urandom_range(0, 2));
        end
      end
    join
    repeat (6) @(posedge clk_i);
    #1;
    mem_auto = 1'b0;
    m_ack_i = 1'b0;
    check("iq_drained", iq.size(), 0);
    check("dq_drained", dq.size(), 0);
    check("wq_drained", wq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, width of all address ports; data ports fixed at 32 bits.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  input  1  reset; synchronous, active-low.
REQ-004 i_addr_i  input  ADDR_W  instruction-fetch address from core.
REQ-005 i_rd_i  input  1  instruction-fetch request; held until i_ready_o.
REQ-006 i_data_o  output  32  fetched instruction, valid while i_ready_o=1.
REQ-007 i_ready_o  output  1  one-cycle completion pulse for fetch.
REQ-008 d_addr_i  input  ADDR_W  data load/store address from core.
REQ-009 d_data_i  input  32  store data from core.
REQ-010 d_rd_i  input  1  load request; held until d_ready_o.
REQ-011 d_wr_i  input  1  store request; held until d_ready_o.
REQ-012 d_data_o  output  32  load data, valid while d_ready_o=1.
REQ-013 d_ready_o  output  1  one-cycle completion pulse for load or store.
REQ-014 m_addr_o  output  ADDR_W  shared memory address.
REQ-015 m_data_o  output  32  shared memory write data.
REQ-016 m_rd_o  output  1  shared memory read strobe, held until m_ack_i.
REQ-017 m_wr_o  output  1  shared memory write strobe, held until m_ack_i.
REQ-018 m_data_i  input  32  shared memory read data, valid with m_ack_i.
REQ-019 m_ack_i  input  1  memory completion, one cycle, at least 1 cycle after strobe.

Function
REQ-020 FSM states: IDLE, GNT_I, GNT_D; exactly one memory transaction in flight.
REQ-021 IDLE: pending data request (d_rd_i|d_wr_i) -> GNT_D; else i_rd_i -> GNT_I; else stay.
REQ-022 On grant edge: m_addr_o, m_data_o, m_rd_o, m_wr_o registered from the winning requester; first strobe cycle is the cycle after the request was sampled.
REQ-023 Memory outputs stay constant through the grant state regardless of requester input changes.
REQ-024 d_rd_i and d_wr_i both high: store is performed (m_wr_o=1, m_rd_o=0).
REQ-025 Instruction grant: m_wr_o=0, m_rd_o=1, m_data_o=0.
REQ-026 GNT_x with m_ack_i=1: strobes drop next edge, x_ready_o pulses for exactly one cycle with x_data_o registered from m_data_i (d_data_o=0 for stores); FSM returns to IDLE.
REQ-027 Minimum request-to-ready latency = 2 + memory wait cycles; back-to-back grants need one IDLE cycle between transactions.
REQ-028 Requester withdrawing its request mid-grant: transaction still completes; ready pulse still issued.
REQ-029 m_ack_i in IDLE ignored; no ready pulse, no state change.
REQ-030 i_data_o / d_data_o hold last value between pulses; ready outputs never high together.

Reset
REQ-031 rst_n_i=0 at an edge: FSM -> IDLE; all outputs 0; round-robin pointer (if present) -> instruction-last.
REQ-032 Reset mid-grant aborts transaction; any later m_ack_i is ignored per REQ-029.

Configuration
REQ-033 Macro ARB_RR_EN defined: when both requesters pending in IDLE, the one not granted last wins; pointer updates on every grant.
REQ-034 ARB_RR_EN undefined: fixed priority data over instruction per REQ-021; no pointer state.

Verification
REQ-035 i_rd_i=1, i_addr_i=0x10, m_ack_i 2 cycles after m_rd_o, m_data_i=0x00500093 -> m_addr_o=0x10, i_ready_o one pulse, i_data_o=0x00500093.
REQ-036 d_wr_i=1, d_addr_i=0x100, d_data_i=0xDEADBEEF -> m_wr_o=1, m_data_o=0xDEADBEEF until ack, d_ready_o one pulse, d_data_o=0.
REQ-037 i_rd_i and d_rd_i asserted same cycle, both held -> data granted first, fetch granted after d_ready_o; with ARB_RR_EN and data granted last, fetch first.
REQ-038 d_rd_i=d_wr_i=1 -> only m_wr_o asserted.
REQ-039 rst_n_i low during GNT_D, then m_ack_i=1 -> outputs 0, no d_ready_o, FSM in IDLE.
